alu_writeback_stage: RTL

Registered stage directly downstream of the n-bit ALU. It captures each ALU result (f, cout, v, z) through a valid/ready handshake and updates the architectural condition-code register (CCR). Register-file writes are queued in a 2-entry buffer so a stalled register-file port does not stall the ALU issue logic for one extra operation.

---
 rtl/alu_writeback_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registered stage behind the ALU.
// It captures ALU results through a valid/ready handshake and updates the
// condition-code register. Register-file writes go through a 2-entry FIFO.
// Optional macro ALU_WB_STICKY_OVF_EN adds a sticky overflow flag
// (ports ovf_pending and ccr_clr).
module alu_writeback_stage #(
    parameter int N  = 8,
    parameter int RA = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_f,
    input  logic          in_cout,
    input  logic          in_v,
    input  logic          in_z,
    input  logic [RA-1:0] in_dst,
    input  logic          in_wr,
    input  logic          in_setcc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [RA-1:0] out_dst,
    output logic [3:0]    ccr
`ifdef ALU_WB_STICKY_OVF_EN
    ,
    output logic          ovf_pending,
    input  logic          ccr_clr
`endif
);

    logic [N-1:0]  data_mem [2];
    logic [RA-1:0] dst_mem  [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          accept;
    logic          push;
    logic          pop;

    // Handshake decode. in_ready comes only from the registered count, so a
    // full buffer never accepts, even when the head is popped on that edge.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        accept    = in_valid & in_ready;
        push      = accept & in_wr;
        pop       = out_valid & out_ready;
        out_data  = data_mem[rd_ptr];
        out_dst   = dst_mem[rd_ptr];
    end

    // Entry storage: write the slot at the write pointer on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                dst_mem[i]  <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= in_f;
            dst_mem[wr_ptr]  <= in_dst;
        end
    end

    // Pointers and occupancy. A simultaneous push and pop leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Condition codes {N,Z,V,C} load on any accepted op that sets them,
    // whether or not that op also writes the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr <= 4'b0000;
        end else if (accept && in_setcc) begin
            ccr <= {in_f[N-1], in_z, in_v, in_cout};
        end
    end

`ifdef ALU_WB_STICKY_OVF_EN
    // Sticky overflow: a new overflow takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_pending <= 1'b0;
        end else if (accept && in_setcc && in_v) begin
            ovf_pending <= 1'b1;
        end else if (ccr_clr) begin
            ovf_pending <= 1'b0;
        end
    end
`endif

endmodule
